// File: rtl/vga_plot_pkg.sv
// Shared types and constants for the VGA plot sink.
//   DEF_SCREEN_W / DEF_SCREEN_H : default framebuffer geometry (160 x 120)
//   ADDR_W                      : framebuffer address width (covers 19200 pixels)
//   x_t / y_t / colour_t        : plot coordinate and colour types
//   state_t                     : sink FSM states
package vga_plot_pkg;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int ADDR_W       = 15;

  typedef logic [7:0]        x_t;
  typedef logic [6:0]        y_t;
  typedef logic [2:0]        colour_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SCAN  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;
endpackage

// File: rtl/vga_plot_sink_if.sv
// Pixel-plot stream as driven by a drawing engine towards the VGA adapter.
//   vga_x, vga_y   : pixel coordinate
//   vga_colour     : pixel colour
//   vga_plot       : write strobe, one pixel per cycle while high
// master = drawing engine, slave = vga_plot_sink.
interface vga_plot_sink_if;
  import vga_plot_pkg::*;

  x_t      vga_x;
  y_t      vga_y;
  colour_t vga_colour;
  logic    vga_plot;

  modport master (output vga_x, vga_y, vga_colour, vga_plot);
  modport slave  (input  vga_x, vga_y, vga_colour, vga_plot);
endinterface

// File: rtl/vga_plot_sink_fb_ram.sv
// fb_ram: simple dual-port framebuffer, one write port, one registered read
// port. A read and write to the same address on the same edge return the
// previously stored data.
//   clk, rst_n           : clock, async active-low reset (read register only)
//   we, waddr, wdata     : write port
//   re, raddr, rdata     : read port, rdata updated on the edge after re
module fb_ram
  import vga_plot_pkg::*;
#(
  parameter int DEPTH = DEF_SCREEN_W * DEF_SCREEN_H
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    we,
  input  addr_t   waddr,
  input  colour_t wdata,
  input  logic    re,
  input  addr_t   raddr,
  output colour_t rdata
);

  // Array contents are intentionally not reset.
  colour_t mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];

endmodule

// File: rtl/vga_plot_sink.sv
// vga_plot_sink: captures a drawing engine's plot stream into a
// SCREEN_W x SCREEN_H x 3-bit framebuffer, with on-demand clear and raster
// read-back.
//   clk, rst_n        : single clock, async active-low reset
//   plot (slave)      : vga_x / vga_y / vga_colour / vga_plot stream
//   clear_start       : clear framebuffer to 0 (wins over scan_start)
//   scan_start        : full raster read-back
//   ready             : high in IDLE
//   scan_valid/x/y/colour : read-back beats, raster order, x fastest
//   done              : one-cycle pulse at end of clear or scan
//   drop_count        : saturating count of rejected plots
//   lit_count         : non-zero pixels seen by the last completed scan
// Optional: define PLOT_SINK_STATS_EN to build drop_count / lit_count;
// otherwise both are tied to 0.
module vga_plot_sink
  import vga_plot_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_plot_sink_if.slave    plot,
  input  logic              clear_start,
  input  logic              scan_start,
  output logic              ready,
  output logic              scan_valid,
  output x_t                scan_x,
  output y_t                scan_y,
  output colour_t           scan_colour,
  output logic              done,
  output logic [15:0]       drop_count,
  output logic [14:0]       lit_count
);

  localparam int    NPIX     = SCREEN_W * SCREEN_H;
  localparam int    STAGES   = 1;
  localparam addr_t LAST     = addr_t'(NPIX - 1);
  localparam addr_t ADDR_END = addr_t'(NPIX);
  localparam x_t    X_LAST   = x_t'(SCREEN_W - 1);

  state_t  state;
  addr_t   cnt;          // clear write address / scan read address
  x_t      cx;
  y_t      cy;

  // Read pipeline: [0] address issued to RAM, [STAGES] RAM data on scan outputs
  logic [STAGES:0] vld_pipe;
  addr_t           rd_addr;
  x_t              rd_x;
  y_t              rd_y;

  logic    in_range, plot_wr;
  addr_t   plot_addr;
  logic    ram_we;
  addr_t   ram_waddr;
  colour_t ram_wdata;

  assign ready      = (state == ST_IDLE);
  assign scan_valid = vld_pipe[STAGES];

  assign in_range  = (int'(plot.vga_x) < SCREEN_W) && (int'(plot.vga_y) < SCREEN_H);
  assign plot_addr = addr_t'(int'(plot.vga_y) * SCREEN_W + int'(plot.vga_x));
  assign plot_wr   = plot.vga_plot && in_range && (state != ST_CLEAR);

  // Clear owns the write port while active; plots arriving then are dropped.
  always_comb begin
    ram_we    = plot_wr;
    ram_waddr = plot_addr;
    ram_wdata = plot.vga_colour;
    if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = cnt;
      ram_wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cx    <= '0;
      cy    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_start) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end else if (scan_start) begin
            state <= ST_SCAN;
            cnt   <= '0;
            cx    <= '0;
            cy    <= '0;
          end
        end
        ST_CLEAR: begin
          if (cnt == LAST) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + addr_t'(1);
          end
        end
        // Addresses are registered before the RAM, so SCAN holds one extra
        // cycle (cnt == ADDR_END) while the last address enters the RAM.
        ST_SCAN: begin
          if (cnt == ADDR_END) begin
            state <= ST_FLUSH;
          end else begin
            cnt <= cnt + addr_t'(1);
            if (cx == X_LAST) begin
              cx <= '0;
              cy <= cy + y_t'(1);
            end else begin
              cx <= cx + x_t'(1);
            end
          end
        end
        ST_FLUSH: begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      rd_addr  <= '0;
      rd_x     <= '0;
      rd_y     <= '0;
      scan_x   <= '0;
      scan_y   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], (state == ST_SCAN) && (cnt != ADDR_END)};
      if (state == ST_SCAN) begin
        rd_addr <= cnt;
        rd_x    <= cx;
        rd_y    <= cy;
      end
      if (vld_pipe[0]) begin
        scan_x <= rd_x;
        scan_y <= rd_y;
      end
    end
  end

  fb_ram #(.DEPTH(NPIX)) u_fb (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (vld_pipe[0]),
    .raddr (rd_addr),
    .rdata (scan_colour)
  );

`ifdef PLOT_SINK_STATS_EN
  logic        plot_drop, beat_lit;
  logic [15:0] drop_q;
  logic [14:0] lit_acc, lit_q;

  assign plot_drop = plot.vga_plot && (!in_range || (state == ST_CLEAR));
  assign beat_lit  = scan_valid && (scan_colour != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q  <= '0;
      lit_acc <= '0;
      lit_q   <= '0;
    end else begin
      if (plot_drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      if ((state == ST_IDLE) && !clear_start && scan_start) lit_acc <= '0;
      else if (beat_lit)                                    lit_acc <= lit_acc + 15'd1;
      // Final beat is on the outputs during FLUSH; fold it in directly.
      if (state == ST_FLUSH) lit_q <= lit_acc + 15'(beat_lit);
    end
  end

  assign drop_count = drop_q;
  assign lit_count  = lit_q;
`else
  assign drop_count = '0;
  assign lit_count  = '0;
`endif

endmodule

// File: tb/tb_vga_plot_sink.sv
module tb_vga_plot_sink;
  import vga_plot_pkg::*;

  localparam int W = 160, H = 120, NPIX = W * H;
`ifdef PLOT_SINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, clear_start = 1'b0, scan_start = 1'b0;
  logic        ready, scan_valid, done;
  x_t          scan_x;
  y_t          scan_y;
  colour_t     scan_colour;
  logic [15:0] drop_count;
  logic [14:0] lit_count;

  vga_plot_sink_if pif ();

  vga_plot_sink #(.SCREEN_W(W), .SCREEN_H(H)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .plot        (pif.slave),
    .clear_start (clear_start),
    .scan_start  (scan_start),
    .ready       (ready),
    .scan_valid  (scan_valid),
    .scan_x      (scan_x),
    .scan_y      (scan_y),
    .scan_colour (scan_colour),
    .done        (done),
    .drop_count  (drop_count),
    .lit_count   (lit_count)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int c; int drop; } plot_vec_t;
  typedef struct { int idx; int x; int y; int c; } beat_vec_t;

  int n_chk = 0, n_fail = 0;
  int exp_drop = 0;
  int exp_fb [NPIX];
  int got_x  [NPIX];
  int got_y  [NPIX];
  int got_c  [NPIX];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic drive_plot(input bit p, input int x, input int y, input int c);
    pif.vga_plot   = p;
    pif.vga_x      = x_t'(x);
    pif.vga_y      = y_t'(y);
    pif.vga_colour = colour_t'(c);
  endtask

  // Runs one clear; plots offered at cycles 3..7 hit addresses already cleared.
  task automatic run_clear(output int done_at);
    bit fin = 1'b0;
    done_at = -1;
    @(negedge clk); clear_start = 1'b1;
    @(posedge clk); #1 clear_start = 1'b0;
    for (int k = 0; k < NPIX + 10 && !fin; k++) begin
      @(negedge clk);
      if (k >= 3 && k <= 7) drive_plot(1'b1, k - 3, 0, 7);
      else if (k == 8)      drive_plot(1'b0, 0, 0, 0);
      if (k == 1) check("ready_low_in_clear", ready, 0);
      if (done) begin
        done_at = k;
        fin     = 1'b1;
        check("ready_with_clear_done", ready, 1);
      end
    end
    exp_drop += 5;
    @(negedge clk);
    check("clear_done_pulse_width", done, 0);
  endtask

  task automatic run_scan(input bit collide, output int beats, output int first_k,
                          output int last_k, output int done_at);
    bit fin = 1'b0;
    beats = 0; first_k = -1; last_k = -1; done_at = -1;
    @(negedge clk); scan_start = 1'b1;
    @(posedge clk); #1 scan_start = 1'b0;
    for (int k = 0; k < NPIX + 10 && !fin; k++) begin
      @(negedge clk);
      if (collide && k == 11)      drive_plot(1'b1, 10, 0, 1);  // lands as address 10 is read
      else if (collide && k == 12) drive_plot(1'b0, 0, 0, 0);
      if (k == 1) check("ready_low_in_scan", ready, 0);
      if (scan_valid) begin
        if (beats < NPIX) begin
          got_x[beats] = int'(scan_x);
          got_y[beats] = int'(scan_y);
          got_c[beats] = int'(scan_colour);
        end
        if (first_k < 0) first_k = k;
        last_k = k;
        beats++;
      end
      if (done) begin
        done_at = k;
        fin     = 1'b1;
        check("ready_with_scan_done", ready, 1);
      end
    end
    @(negedge clk);
    check("scan_done_pulse_width", done, 0);
  endtask

  task automatic check_scan(input string tag, input int beats, input int first_k,
                            input int last_k, input int done_at);
    int bad_c = 0, bad_xy = 0;
    check({tag, "_beats"},      beats,   NPIX);
    check({tag, "_first_beat"}, first_k, 2);
    check({tag, "_last_beat"},  last_k,  NPIX + 1);
    check({tag, "_done_cycle"}, done_at, NPIX + 2);
    for (int i = 0; i < NPIX; i++) begin
      if (got_c[i] != exp_fb[i]) bad_c++;
      if (got_x[i] != i % W || got_y[i] != i / W) bad_xy++;
    end
    check({tag, "_colour_errs"}, bad_c,  0);
    check({tag, "_coord_errs"},  bad_xy, 0);
  endtask

  initial begin
    plot_vec_t ptab [6];
    beat_vec_t btab1 [4];
    beat_vec_t btab2 [2];
    int beats, first_k, last_k, done_at;
    bit done_seen;

    ptab = '{'{0, 0, 2, 0}, '{159, 119, 7, 0}, '{80, 60, 5, 0},
             '{160, 0, 7, 1}, '{0, 120, 7, 1}, '{255, 127, 3, 1}};
    btab1 = '{'{0, 0, 0, 2}, '{10, 10, 0, 0}, '{9680, 80, 60, 5}, '{19199, 159, 119, 7}};
    btab2 = '{'{10, 10, 0, 1}, '{0, 0, 0, 2}};
    foreach (exp_fb[i]) exp_fb[i] = 0;
    drive_plot(1'b0, 0, 0, 0);

    // Reset values
    #12;
    check("rst_ready",       ready,       1);
    check("rst_scan_valid",  scan_valid,  0);
    check("rst_scan_x",      scan_x,      0);
    check("rst_scan_y",      scan_y,      0);
    check("rst_scan_colour", scan_colour, 0);
    check("rst_done",        done,        0);
    check("rst_drop_count",  drop_count,  0);
    check("rst_lit_count",   lit_count,   0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    // Reset in the middle of a scan
    @(negedge clk); scan_start = 1'b1;
    @(posedge clk); #1 scan_start = 1'b0;
    repeat (5000) @(negedge clk);
    check("midscan_valid_before_rst", scan_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midscan_rst_ready", ready,      1);
    check("midscan_rst_valid", scan_valid, 0);
    done_seen = 1'b0;
    repeat (3) begin @(negedge clk); done_seen |= done; end
    rst_n = 1'b1;
    repeat (5) begin @(negedge clk); done_seen |= done | scan_valid; end
    check("midscan_no_done_or_valid", done_seen, 0);
    check("midscan_idle_after_rst",   ready,     1);

    // Clear, with plots offered during it
    run_clear(done_at);
    check("clear_done_cycle",  done_at,    NPIX);
    check("clear_drop_count",  drop_count, STATS ? exp_drop : 0);

    // Plot table: in-range and out-of-range writes
    foreach (ptab[i]) begin
      @(negedge clk);
      drive_plot(1'b1, ptab[i].x, ptab[i].y, ptab[i].c);
      @(negedge clk);
      drive_plot(1'b0, 0, 0, 0);
      exp_drop += ptab[i].drop;
      if (ptab[i].drop == 0) exp_fb[ptab[i].y * W + ptab[i].x] = ptab[i].c;
      check($sformatf("plot%0d_drop_count", i), drop_count, STATS ? exp_drop : 0);
    end

    // Scan 1: plot to address 10 collides with its read, old data expected
    run_scan(1'b1, beats, first_k, last_k, done_at);
    check_scan("scan1", beats, first_k, last_k, done_at);
    foreach (btab1[i]) begin
      check($sformatf("scan1_beat%0d_x", btab1[i].idx), got_x[btab1[i].idx], btab1[i].x);
      check($sformatf("scan1_beat%0d_y", btab1[i].idx), got_y[btab1[i].idx], btab1[i].y);
      check($sformatf("scan1_beat%0d_c", btab1[i].idx), got_c[btab1[i].idx], btab1[i].c);
    end
    check("scan1_lit_count",  lit_count,  STATS ? 3 : 0);
    check("scan1_drop_count", drop_count, STATS ? exp_drop : 0);

    // Scan 2: collided write is now visible
    exp_fb[10] = 1;
    run_scan(1'b0, beats, first_k, last_k, done_at);
    check_scan("scan2", beats, first_k, last_k, done_at);
    foreach (btab2[i])
      check($sformatf("scan2_beat%0d_c", btab2[i].idx), got_c[btab2[i].idx], btab2[i].c);
    check("scan2_lit_count",  lit_count,  STATS ? 4 : 0);
    check("scan2_drop_count", drop_count, STATS ? exp_drop : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
